// File: rtl/cpu_types_pkg.sv
// Shared types for the data-memory request controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } req_state_t;

  typedef enum logic [1:0] {
    RK_LOAD  = 2'd0,
    RK_STORE = 2'd1,
    RK_LL    = 2'd2,
    RK_SC    = 2'd3
  } req_kind_t;

  // Classify a decoded request; ll/sc qualifiers only count with their matching enable.
  function automatic req_kind_t decode_kind(input logic ren, input logic wen,
                                            input logic ll, input logic sc);
    if (ren && ll)      return RK_LL;
    else if (wen && sc) return RK_SC;
    else if (wen)       return RK_STORE;
    else                return RK_LOAD;
  endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: word address, valid bit and snoop invalidation.
module link_reg #(
  parameter int unsigned WORD_W = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              clear_i,
  input  logic              snoop_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  input  logic [WORD_W-1:0] cmp_addr_i,
  output logic              match_c,
  output logic              valid_o
);

  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              valid_q, valid_d;

  // Next link state: set beats a same-cycle snoop, clear or matching snoop drops the link.
  always_comb begin
    link_addr_d = link_addr_q;
    valid_d     = valid_q;
    if (clear_i || (snoop_i && valid_q && (snoop_addr_i == link_addr_q))) begin
      valid_d = 1'b0;
    end
    if (set_i) begin
      valid_d     = 1'b1;
      link_addr_d = set_addr_i;
    end
  end

  // Link state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      link_addr_q <= link_addr_d;
      valid_q     <= valid_d;
    end
  end

  assign match_c = valid_q && (cmp_addr_i == link_addr_q);
  assign valid_o = valid_q;

endmodule

// File: rtl/mem_request_ctrl.sv
// Data-memory request latch with PC stall, LL/SC link tracking, timeout monitor and halt.
module mem_request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned TIMEOUT_W     = 8,
  parameter int unsigned TIMEOUT_LIMIT = 200
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic              halt_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dstore_i,
  input  logic              snoop_inv_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              dREN_o,
  output logic              dWEN_o,
  output logic [ADDR_W-1:0] daddr_o,
  output logic [DATA_W-1:0] dstore_o,
  output logic              pc_enable,
  output logic              sc_valid_o,
  output logic              sc_result_o,
  output logic              link_valid_o,
  output logic              timeout_o,
  output logic              halted_o
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  req_state_t        state_q, state_d;
  req_kind_t         kind_q, kind_d;
  logic              dren_q, dren_d;
  logic              dwen_q, dwen_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dstore_q, dstore_d;
  logic              sc_valid_q, sc_valid_d;
  logic              sc_result_q, sc_result_d;
  logic              timeout_q, timeout_d;
  logic              halted_q, halted_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic              link_set, link_clr, link_match;
  logic [WORD_W-1:0] cmp_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^snoop_addr_i[1:0];

  // Compare the incoming address while idle (SC check), the held address while pending.
  assign cmp_word = (state_q == PEND) ? daddr_q[ADDR_W-1:2] : daddr_i[ADDR_W-1:2];

  link_reg #(.WORD_W(WORD_W)) u_link (
    .CLK          (CLK),
    .RST          (RST),
    .set_i        (link_set),
    .set_addr_i   (daddr_q[ADDR_W-1:2]),
    .clear_i      (link_clr),
    .snoop_i      (snoop_inv_i),
    .snoop_addr_i (snoop_addr_i[ADDR_W-1:2]),
    .cmp_addr_i   (cmp_word),
    .match_c      (link_match),
    .valid_o      (link_valid_o)
  );

  // Next-state, capture, link control and PC enable.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    dren_d      = dren_q;
    dwen_d      = dwen_q;
    daddr_d     = daddr_q;
    dstore_d    = dstore_q;
    sc_valid_d  = 1'b0;
    sc_result_d = 1'b0;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    link_set    = 1'b0;
    link_clr    = 1'b0;
    pc_enable   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ihit) begin
          if (halt_i) begin
            state_d = HALTED;
          end else if (dREN_i || dWEN_i) begin
            daddr_d  = daddr_i;
            dstore_d = dstore_i;
            kind_d   = decode_kind(dREN_i, dWEN_i, ll_i, sc_i);
            cnt_d    = '0;
            if (dWEN_i && sc_i && !link_match) begin
              // Failed SC resolves immediately without touching memory.
              sc_valid_d = 1'b1;
              pc_enable  = 1'b1;
            end else begin
              state_d = PEND;
              dren_d  = dREN_i;
              dwen_d  = dWEN_i;
            end
          end else begin
            pc_enable = 1'b1;
          end
        end
      end
      PEND: begin
        if (dhit) begin
          state_d   = IDLE;
          dren_d    = 1'b0;
          dwen_d    = 1'b0;
          cnt_d     = '0;
          pc_enable = 1'b1;
          case (kind_q)
            RK_LL: link_set = 1'b1;
            RK_SC: begin
              sc_valid_d  = 1'b1;
              sc_result_d = 1'b1;
              link_clr    = 1'b1;
            end
            RK_STORE: link_clr = link_match;
            default:  link_clr = 1'b0;
          endcase
        end else begin
          if (cnt_q != {TIMEOUT_W{1'b1}}) cnt_d = cnt_q + TIMEOUT_W'(1);
          if (cnt_d == TIMEOUT_W'(TIMEOUT_LIMIT)) timeout_d = 1'b1;
        end
      end
      HALTED: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase

    halted_d = (state_d == HALTED);
  end

  // Controller registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      kind_q      <= RK_LOAD;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      daddr_q     <= '0;
      dstore_q    <= '0;
      sc_valid_q  <= 1'b0;
      sc_result_q <= 1'b0;
      timeout_q   <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      dren_q      <= dren_d;
      dwen_q      <= dwen_d;
      daddr_q     <= daddr_d;
      dstore_q    <= dstore_d;
      sc_valid_q  <= sc_valid_d;
      sc_result_q <= sc_result_d;
      timeout_q   <= timeout_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dREN_o      = dren_q;
  assign dWEN_o      = dwen_q;
  assign daddr_o     = daddr_q;
  assign dstore_o    = dstore_q;
  assign sc_valid_o  = sc_valid_q;
  assign sc_result_o = sc_result_q;
  assign timeout_o   = timeout_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed bench for mem_request_ctrl (TIMEOUT_LIMIT overridden to 4).
module tb_mem_request_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, dREN_i, dWEN_i, ll_i, sc_i, halt_i, snoop_inv_i;
  logic [31:0] daddr_i, dstore_i, snoop_addr_i;
  logic        dREN_o, dWEN_o, pc_enable, sc_valid_o, sc_result_o;
  logic        link_valid_o, timeout_o, halted_o;
  logic [31:0] daddr_o, dstore_o;

  int checks = 0;
  int errors = 0;

  mem_request_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8), .TIMEOUT_LIMIT(4)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_i(dREN_i), .dWEN_i(dWEN_i), .ll_i(ll_i), .sc_i(sc_i), .halt_i(halt_i),
    .daddr_i(daddr_i), .dstore_i(dstore_i),
    .snoop_inv_i(snoop_inv_i), .snoop_addr_i(snoop_addr_i),
    .dREN_o(dREN_o), .dWEN_o(dWEN_o), .daddr_o(daddr_o), .dstore_o(dstore_o),
    .pc_enable(pc_enable), .sc_valid_o(sc_valid_o), .sc_result_o(sc_result_o),
    .link_valid_o(link_valid_o), .timeout_o(timeout_o), .halted_o(halted_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; dREN_i = 0; dWEN_i = 0; ll_i = 0; sc_i = 0; halt_i = 0;
    snoop_inv_i = 0; daddr_i = '0; dstore_i = '0; snoop_addr_i = '0;
  endtask

  // One-cycle request issue with ihit, then inputs return to idle.
  task automatic do_req(input logic ren, input logic wen, input logic ll, input logic sc,
                        input logic [31:0] addr, input logic [31:0] data);
    ihit = 1; dREN_i = ren; dWEN_i = wen; ll_i = ll; sc_i = sc; daddr_i = addr; dstore_i = data;
    tick();
    clear_inputs();
  endtask

  task automatic do_dhit();
    dhit = 1;
    tick();
    dhit = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    tick(); tick();
    checks++; if (dREN_o !== 1'b0) begin errors++; $display("FAIL rst_dren got=%0b exp=0", dREN_o); end
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL rst_dwen got=%0b exp=0", dWEN_o); end
    checks++; if (daddr_o !== 32'h0) begin errors++; $display("FAIL rst_daddr got=%h exp=0", daddr_o); end
    checks++; if (dstore_o !== 32'h0) begin errors++; $display("FAIL rst_dstore got=%h exp=0", dstore_o); end
    checks++; if (sc_valid_o !== 1'b0) begin errors++; $display("FAIL rst_scv got=%0b exp=0", sc_valid_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL rst_link got=%0b exp=0", link_valid_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%0b exp=0", timeout_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted_o); end
    RST = 0;
    ihit = 1;
    #1;
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL rst_ihit_pc got=%0b exp=1", pc_enable); end
    tick();
    ihit = 0;
    checks++; if (dREN_o !== 1'b0) begin errors++; $display("FAIL rst_noreq_dren got=%0b exp=0", dREN_o); end
  endtask

  task automatic test_load();
    ihit = 1; dREN_i = 1; daddr_i = 32'h100;
    #1;
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL ld_issue_pc got=%0b exp=0", pc_enable); end
    tick();
    clear_inputs();
    #1;
    checks++; if (dREN_o !== 1'b1) begin errors++; $display("FAIL ld_c1_dren got=%0b exp=1", dREN_o); end
    checks++; if (daddr_o !== 32'h100) begin errors++; $display("FAIL ld_c1_addr got=%h exp=100", daddr_o); end
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL ld_c1_pc got=%0b exp=0", pc_enable); end
    // New request during PEND must be ignored.
    ihit = 1; dWEN_i = 1; daddr_i = 32'h500;
    #1;
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL ld_pend_ihit_pc got=%0b exp=0", pc_enable); end
    tick();
    clear_inputs();
    checks++; if (dREN_o !== 1'b1) begin errors++; $display("FAIL ld_c2_dren got=%0b exp=1", dREN_o); end
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL ld_c2_dwen got=%0b exp=0", dWEN_o); end
    checks++; if (daddr_o !== 32'h100) begin errors++; $display("FAIL ld_c2_addr got=%h exp=100", daddr_o); end
    dhit = 1;
    #1;
    checks++; if (dREN_o !== 1'b1) begin errors++; $display("FAIL ld_c3_dren got=%0b exp=1", dREN_o); end
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL ld_dhit_pc got=%0b exp=1", pc_enable); end
    tick();
    dhit = 0;
    #1;
    checks++; if (dREN_o !== 1'b0) begin errors++; $display("FAIL ld_done_dren got=%0b exp=0", dREN_o); end
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL ld_done_pc got=%0b exp=0", pc_enable); end
  endtask

  task automatic test_ll_sc_success();
    do_req(1, 0, 1, 0, 32'h200, 32'h0);
    checks++; if (dREN_o !== 1'b1) begin errors++; $display("FAIL llsc_ll_dren got=%0b exp=1", dREN_o); end
    do_dhit();
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL llsc_link_set got=%0b exp=1", link_valid_o); end
    ihit = 1; dWEN_i = 1; sc_i = 1; daddr_i = 32'h200; dstore_i = 32'hDEAD;
    #1;
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL llsc_sc_issue_pc got=%0b exp=0", pc_enable); end
    tick();
    clear_inputs();
    checks++; if (dWEN_o !== 1'b1) begin errors++; $display("FAIL llsc_sc_dwen got=%0b exp=1", dWEN_o); end
    checks++; if (dstore_o !== 32'hDEAD) begin errors++; $display("FAIL llsc_sc_data got=%h exp=dead", dstore_o); end
    checks++; if (sc_valid_o !== 1'b0) begin errors++; $display("FAIL llsc_scv_early got=%0b exp=0", sc_valid_o); end
    dhit = 1;
    #1;
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL llsc_dhit_pc got=%0b exp=1", pc_enable); end
    tick();
    dhit = 0;
    checks++; if (sc_valid_o !== 1'b1) begin errors++; $display("FAIL llsc_scv got=%0b exp=1", sc_valid_o); end
    checks++; if (sc_result_o !== 1'b1) begin errors++; $display("FAIL llsc_scr got=%0b exp=1", sc_result_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL llsc_link_clr got=%0b exp=0", link_valid_o); end
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL llsc_dwen_drop got=%0b exp=0", dWEN_o); end
    tick();
    checks++; if (sc_valid_o !== 1'b0) begin errors++; $display("FAIL llsc_scv_pulse got=%0b exp=0", sc_valid_o); end
  endtask

  task automatic test_snoop_fail();
    do_req(1, 0, 1, 0, 32'h200, 32'h0);
    do_dhit();
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL snp_link_set got=%0b exp=1", link_valid_o); end
    snoop_inv_i = 1; snoop_addr_i = 32'h204;
    tick();
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL snp_other_word got=%0b exp=1", link_valid_o); end
    snoop_addr_i = 32'h202;
    tick();
    snoop_inv_i = 0;
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL snp_clear got=%0b exp=0", link_valid_o); end
    ihit = 1; dWEN_i = 1; sc_i = 1; daddr_i = 32'h200; dstore_i = 32'hBEEF;
    #1;
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL snp_scfail_pc got=%0b exp=1", pc_enable); end
    tick();
    clear_inputs();
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL snp_scfail_dwen got=%0b exp=0", dWEN_o); end
    checks++; if (sc_valid_o !== 1'b1) begin errors++; $display("FAIL snp_scfail_scv got=%0b exp=1", sc_valid_o); end
    checks++; if (sc_result_o !== 1'b0) begin errors++; $display("FAIL snp_scfail_scr got=%0b exp=0", sc_result_o); end
    tick();
    checks++; if (sc_valid_o !== 1'b0) begin errors++; $display("FAIL snp_scv_pulse got=%0b exp=0", sc_valid_o); end
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL snp_idle_dwen got=%0b exp=0", dWEN_o); end
    // LL completion beats a same-cycle matching snoop.
    do_req(1, 0, 1, 0, 32'h300, 32'h0);
    dhit = 1; snoop_inv_i = 1; snoop_addr_i = 32'h300;
    tick();
    clear_inputs();
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL snp_ll_wins got=%0b exp=1", link_valid_o); end
    // Ordinary store to the linked word (different byte offset) clears the link on completion.
    do_req(0, 1, 0, 0, 32'h303, 32'h5);
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL snp_st_pend_link got=%0b exp=1", link_valid_o); end
    do_dhit();
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL snp_st_clear got=%0b exp=0", link_valid_o); end
  endtask

  task automatic test_timeout();
    do_req(0, 1, 0, 0, 32'h40, 32'h1234);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_early_c%0d got=%0b exp=0", i, timeout_o); end
    end
    tick();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_rise got=%0b exp=1", timeout_o); end
    checks++; if (dWEN_o !== 1'b1) begin errors++; $display("FAIL to_req_held got=%0b exp=1", dWEN_o); end
    do_dhit();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky got=%0b exp=1", timeout_o); end
    checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL to_done_dwen got=%0b exp=0", dWEN_o); end
    do_reset();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_rst_clear got=%0b exp=0", timeout_o); end
  endtask

  task automatic test_reset_mid_pend();
    do_req(1, 0, 1, 0, 32'h80, 32'h0);
    do_dhit();
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL rmp_link_set got=%0b exp=1", link_valid_o); end
    do_req(1, 0, 0, 0, 32'h84, 32'h0);
    checks++; if (dREN_o !== 1'b1) begin errors++; $display("FAIL rmp_dren got=%0b exp=1", dREN_o); end
    do_reset();
    checks++; if (dREN_o !== 1'b0) begin errors++; $display("FAIL rmp_dren_drop got=%0b exp=0", dREN_o); end
    checks++; if (daddr_o !== 32'h0) begin errors++; $display("FAIL rmp_daddr got=%h exp=0", daddr_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL rmp_link got=%0b exp=0", link_valid_o); end
    checks++; if (sc_valid_o !== 1'b0) begin errors++; $display("FAIL rmp_scv got=%0b exp=0", sc_valid_o); end
    ihit = 1;
    #1;
    checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL rmp_idle_pc got=%0b exp=1", pc_enable); end
    tick();
    ihit = 0;
  endtask

  task automatic test_halt();
    ihit = 1; halt_i = 1; dWEN_i = 1; daddr_i = 32'h10;
    #1;
    checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL halt_issue_pc got=%0b exp=0", pc_enable); end
    tick();
    clear_inputs();
    ihit = 1; dREN_i = 1; daddr_i = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_c%0d_halted got=%0b exp=1", i, halted_o); end
      checks++; if (dWEN_o !== 1'b0) begin errors++; $display("FAIL halt_c%0d_dwen got=%0b exp=0", i, dWEN_o); end
      checks++; if (dREN_o !== 1'b0) begin errors++; $display("FAIL halt_c%0d_dren got=%0b exp=0", i, dREN_o); end
      checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL halt_c%0d_pc got=%0b exp=0", i, pc_enable); end
      tick();
    end
    clear_inputs();
    do_reset();
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL halt_rst got=%0b exp=0", halted_o); end
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    test_reset();
    test_load();
    test_ll_sc_success();
    test_snoop_fail();
    test_timeout();
    test_reset_mid_pend();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
